// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared types and constants for the data memory responder:
//   - state_t      : responder FSM states (IDLE / WAIT / RESP)
//   - wait_cnt_t   : 4-bit wait-state counter (WAIT_CYCLES range 0..15)
//   - WORD_W, BYTE_W, LANES : word and byte-lane geometry
//   - lane_mask()  : expands per-lane enables into a per-bit write mask
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [3:0] wait_cnt_t;

  function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] lane_en);
    logic [WORD_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i*BYTE_W +: BYTE_W] = {BYTE_W{lane_en[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bus between an initiator and the data memory responder.
//   req_valid/req_ready : request handshake (initiator -> responder)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte strobes (bit i = lane i)
//   rsp_valid/rsp_ready : response handshake (responder -> initiator)
//   rsp_rdata, rsp_err  : load data (0 for stores/errors), error flag
// Modports: master = initiator side, slave = responder side.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// -----------------------------------------------------------------------------
// data_mem_responder_array
// DEPTH x 32-bit word storage: synchronous write with byte-lane enables,
// combinational read of the same index, every word cleared while rst is low.
// Ports:
//   clk       : clock
//   rst       : synchronous active-low reset (clears all words)
//   i_we      : write enable
//   i_idx     : word index (read and write)
//   i_wdata   : write data
//   i_lane_en : per-byte-lane write enables
//   o_rdata   : combinational read data at i_idx
// -----------------------------------------------------------------------------
module data_mem_responder_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [LANES-1:0]  i_lane_en,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] w_mask;

  assign w_mask = lane_mask(i_lane_en);

  // NOTE: clearing every word on reset turns the array into plain flops and
  // rules out RAM-macro inference; it is kept because software relies on
  // memory reading zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding load/store responder in front of a DEPTH-word memory.
// A request is accepted in IDLE, optionally waits WAIT_CYCLES cycles, and the
// memory access (store write or load capture) happens on the edge entering
// RESP. The response is held until the initiator takes it.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-low reset
//   bus : data_mem_responder_if.slave (request/response handshakes)
// Parameters:
//   DEPTH       : number of 32-bit words
//   WAIT_CYCLES : wait states between accept and response (0..15)
// Build option:
//   DATA_MEM_RESPONDER_BYTE_STROBE_EN : when defined, stores honour req_be;
//   otherwise every non-error store writes the full word.
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  wait_cnt_t         r_cnt;
  wait_cnt_t         w_cnt_nxt;
  logic              w_accept;
  logic              w_commit;

  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [LANES-1:0]  r_be;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;

  logic              w_c_we;
  logic [WORD_W-1:0] w_c_addr;
  logic [WORD_W-1:0] w_c_wdata;
  logic [LANES-1:0]  w_c_be;
  logic              w_c_err;
  logic [IDX_W-1:0]  w_c_idx;
  logic [LANES-1:0]  w_lane_en;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_mem_rdata;

  // With zero wait states the commit happens on the accept edge itself, so the
  // access must use the live request; otherwise it uses the registered copy.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_c_we    = bus.req_we;
      w_c_addr  = bus.req_addr;
      w_c_wdata = bus.req_wdata;
      w_c_be    = bus.req_be;
    end else begin
      w_c_we    = r_we;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
      w_c_be    = r_be;
    end
  end

  assign w_c_err  = (w_c_addr[1:0] != 2'b00) ||
                    ({2'b00, w_c_addr[WORD_W-1:2]} >= WORD_W'(DEPTH));
  assign w_c_idx  = w_c_addr[IDX_W+1:2];
  assign w_mem_we = w_commit && w_c_we && !w_c_err;

`ifdef DATA_MEM_RESPONDER_BYTE_STROBE_EN
  assign w_lane_en = w_c_be;
`else
  // Strobes have no effect in this build; every store writes the full word.
  logic w_unused_be;
  assign w_lane_en   = '1;
  assign w_unused_be = ^w_c_be;
`endif

  data_mem_responder_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_mem_we),
    .i_idx     (w_c_idx),
    .i_wdata   (w_c_wdata),
    .i_lane_en (w_lane_en),
    .o_rdata   (w_mem_rdata)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = wait_cnt_t'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // Leaving RESP always passes through IDLE, giving one idle cycle.
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_commit) begin
        r_err   <= w_c_err;
        r_rdata <= (w_c_we || w_c_err) ? '0 : w_mem_rdata;
      end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
